// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with packet lock for a router output port.
// Grant is combinational from REQ/EN/state; PTR/OWNER/FSM advance on CLK.
// Optional hold timeout enabled by defining RR_ARB_HOLD_TIMEOUT_EN.
module rr_lock_arbiter #(
    parameter int NR       = 6,
    parameter int MAX_HOLD = 16,
    parameter int IW       = $clog2(NR)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [NR-1:0] REQ,
    input  logic [NR-1:0] TAIL,
    input  logic          EN,
    output logic [NR-1:0] GRT,
    output logic          GRT_VLD,
    output logic [IW-1:0] GRT_IDX,
    output logic          LOCKED,
    output logic          TIMEOUT
);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    // Elaboration-time sanity checks on the configuration.
    if (NR < 2)       begin : g_chk_nr   $error("NR must be >= 2");       end
    if (MAX_HOLD < 2) begin : g_chk_hold $error("MAX_HOLD must be >= 2"); end

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] pick;
    logic          any;
    logic          hold_to;

    // (idx+1) mod NR without relying on power-of-two NR.
    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(NR-1)) ? '0 : i + IW'(1);
    endfunction

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0] cnt, cnt_n;

    // Counter value is the number of completed lock cycles; the current
    // cycle brings it to MAX_HOLD-1, so release fires when cnt is MAX_HOLD-2.
    // Tail transfer or abort in the same cycle take the normal release path.
    always_comb begin
        hold_to = (state == S_LOCKED) && REQ[owner] && !(EN && TAIL[owner])
                  && (cnt == CW'(MAX_HOLD-2));
    end

    // Hold counter register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cnt <= '0;
        else       cnt <= cnt_n;
    end
`else
    // Locks are unbounded in this build.
    always_comb begin
        hold_to = 1'b0;
    end
`endif

    // Rotating-priority scan: first set REQ bit from ptr upward, wrapping.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = 0; k < NR; k++) begin
            int            jn;
            logic [IW-1:0] j;
            jn = int'(ptr) + k;
            if (jn >= NR) jn = jn - NR;
            j = IW'(jn);
            if (!any && REQ[j]) begin
                any  = 1'b1;
                pick = j;
            end
        end
    end

    // State, priority pointer and owner registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
        end
    end

    // Next-state: lock on multi-flit grant, release on tail/abort/timeout.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        cnt_n   = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (EN && any) begin
                    if (TAIL[pick]) begin
                        ptr_n = nxt(pick);
                    end else begin
                        state_n = S_LOCKED;
                        owner_n = pick;
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end
                end
            end
            S_LOCKED: begin
                // Abort wins over stall: a dropped request releases even with EN=0.
                if (!REQ[owner] || (EN && TAIL[owner]) || hold_to) begin
                    state_n = S_IDLE;
                    ptr_n   = nxt(owner);
                end else begin
`ifdef RR_ARB_HOLD_TIMEOUT_EN
                    cnt_n = cnt + CW'(1);
`endif
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs: zero-latency grant, all forced low while reset is asserted.
    always_comb begin
        GRT     = '0;
        GRT_IDX = '0;
        LOCKED  = 1'b0;
        TIMEOUT = 1'b0;
        if (RSTn) begin
            LOCKED  = (state == S_LOCKED);
            TIMEOUT = hold_to;
            if (state == S_IDLE) begin
                if (EN && any) begin
                    GRT[pick] = 1'b1;
                    GRT_IDX   = pick;
                end
            end else if (EN && REQ[owner]) begin
                GRT[owner] = 1'b1;
                GRT_IDX    = owner;
            end
        end
        GRT_VLD = |GRT;
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NR=6, MAX_HOLD=4): the driver pushes
// hand-computed expectations into a queue, a negedge monitor pops and compares.
module tb_rr_lock_arbiter;

    localparam int NR = 6;
    localparam int IW = 3;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic [NR-1:0] REQ = '0;
    logic [NR-1:0] TAIL = '0;
    logic          EN = 1'b1;
    logic [NR-1:0] GRT;
    logic          GRT_VLD;
    logic [IW-1:0] GRT_IDX;
    logic          LOCKED;
    logic          TIMEOUT;

    rr_lock_arbiter #(.NR(NR), .MAX_HOLD(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .TAIL(TAIL), .EN(EN),
        .GRT(GRT), .GRT_VLD(GRT_VLD), .GRT_IDX(GRT_IDX),
        .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NR-1:0] grt;
        logic          lk;
        logic          to;
        string         nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [IW-1:0] enc(input logic [NR-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (v[i]) r = IW'(i);
        return r;
    endfunction

    // Drive one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic step(input logic rst, input logic [NR-1:0] req, input logic [NR-1:0] tail,
                        input logic en, input logic [NR-1:0] eg, input logic el,
                        input logic et, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        RSTn = rst;
        REQ  = req;
        TAIL = tail;
        EN   = en;
        e.grt = eg;
        e.lk  = el;
        e.to  = et;
        e.nm  = nm;
        q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t          e;
            logic [12:0]   act, req_v;
            e = q.pop_front();
            act   = {GRT, GRT_IDX, GRT_VLD, LOCKED, TIMEOUT};
            req_v = {e.grt, enc(e.grt), |e.grt, e.lk, e.to};
            checks++;
            if (act !== req_v) begin
                errors++;
                $display("FAIL %s: got grt=%b idx=%0d vld=%b lk=%b to=%b, need grt=%b idx=%0d vld=%b lk=%b to=%b",
                         e.nm, GRT, GRT_IDX, GRT_VLD, LOCKED, TIMEOUT,
                         e.grt, enc(e.grt), |e.grt, e.lk, e.to);
            end
        end
    end

    initial begin
        // Reset holds outputs low even with a request present.
        step(0, 6'b100000, 6'b111111, 1, 6'b000000, 0, 0, "rst0");
        step(0, 6'b100000, 6'b111111, 1, 6'b000000, 0, 0, "rst1");
        step(1, 6'b100000, 6'b111111, 1, 6'b100000, 0, 0, "rst_release");  // ptr 5->0
        // Fairness from ptr=0.
        step(1, 6'b111111, 6'b111111, 1, 6'b000001, 0, 0, "fair0");
        step(1, 6'b111111, 6'b111111, 1, 6'b000010, 0, 0, "fair1");
        step(1, 6'b111111, 6'b111111, 1, 6'b000100, 0, 0, "fair2");
        step(1, 6'b111111, 6'b111111, 1, 6'b001000, 0, 0, "fair3");
        step(1, 6'b111111, 6'b111111, 1, 6'b010000, 0, 0, "fair4");
        step(1, 6'b111111, 6'b111111, 1, 6'b100000, 0, 0, "fair5");
        step(1, 6'b111111, 6'b111111, 1, 6'b000001, 0, 0, "fair6_wrap"); // ptr=1
        step(1, 6'b100000, 6'b111111, 1, 6'b100000, 0, 0, "wrap_to0");   // ptr=0
        // Lock on requester 0; no handover in the release cycle.
        step(1, 6'b110001, 6'b000000, 1, 6'b000001, 0, 0, "lock1");
        step(1, 6'b110001, 6'b000000, 1, 6'b000001, 1, 0, "lock2");
        step(1, 6'b110001, 6'b000000, 1, 6'b000001, 1, 0, "lock3");
        step(1, 6'b110001, 6'b000001, 1, 6'b000001, 1, 0, "lock_tail");  // ptr=1
        step(1, 6'b110001, 6'b111111, 1, 6'b010000, 0, 0, "after_lock"); // ptr=5
        // Stall with owner 2, other requests ignored while locked.
        step(1, 6'b000100, 6'b000000, 1, 6'b000100, 0, 0, "stall_acq");
        step(1, 6'b000100, 6'b000000, 0, 6'b000000, 1, 0, "stall0");
        step(1, 6'b000100, 6'b000000, 0, 6'b000000, 1, 0, "stall1");
        step(1, 6'b010100, 6'b000000, 1, 6'b000100, 1, 0, "stall_resume");
        step(1, 6'b010100, 6'b000100, 1, 6'b000100, 1, 0, "stall_tail");  // ptr=3
        // Abort with owner 3.
        step(1, 6'b001000, 6'b000000, 1, 6'b001000, 0, 0, "abort_acq");
        step(1, 6'b001000, 6'b000000, 1, 6'b001000, 1, 0, "abort_hold");
        step(1, 6'b110000, 6'b000000, 1, 6'b000000, 1, 0, "abort");       // ptr=4
        step(1, 6'b110000, 6'b111111, 1, 6'b010000, 0, 0, "after_abort"); // ptr=5
        // Abort beats stall.
        step(1, 6'b000001, 6'b000000, 1, 6'b000001, 0, 0, "ab_st_acq");
        step(1, 6'b000000, 6'b000000, 0, 6'b000000, 1, 0, "ab_st");       // ptr=1
        step(1, 6'b000011, 6'b111111, 1, 6'b000010, 0, 0, "ab_st_next");  // ptr=2
        // EN=0 and REQ=0 in IDLE leave state alone.
        step(1, 6'b111111, 6'b111111, 0, 6'b000000, 0, 0, "idle_en0");
        step(1, 6'b000000, 6'b111111, 1, 6'b000000, 0, 0, "idle_req0");
        step(1, 6'b111111, 6'b111111, 1, 6'b000100, 0, 0, "idle_resume"); // ptr=3
        step(1, 6'b100000, 6'b111111, 1, 6'b100000, 0, 0, "to_prep");     // ptr=0
        // Hold timeout (MAX_HOLD=4).
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 0, 0, "hold1");
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 1, 0, "hold2");
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 1, 0, "hold3");
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 1, 1, "hold4_to");
        step(1, 6'b000011, 6'b000000, 1, 6'b000010, 0, 0, "hold5");
        step(1, 6'b000011, 6'b000000, 1, 6'b000010, 1, 0, "hold6");
`else
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 1, 0, "hold4");
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 1, 0, "hold5");
        step(1, 6'b000011, 6'b000000, 1, 6'b000001, 1, 0, "hold6");
`endif
        // Reset mid-packet drops the lock; arbitration restarts at ptr=0.
        step(0, 6'b000011, 6'b000000, 1, 6'b000000, 0, 0, "midrst");
        step(1, 6'b100001, 6'b111111, 1, 6'b000001, 0, 0, "midrst_rel");  // ptr=1
        step(1, 6'b100001, 6'b111111, 1, 6'b100000, 0, 0, "midrst_next");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
